omsp_clkgen_multi: RTL



---
 rtl/omsp_clkgen_pkg.sv | 43 ++++
 rtl/omsp_clkgen_ch.sv | 79 +++++++
 rtl/omsp_clkgen_multi.sv | 109 ++++++++++
 3 files changed

// File: rtl/omsp_clkgen_pkg.sv
// -----------------------------------------------------------------------------
// omsp_clkgen_pkg
//   Shared definitions for the multi-channel clock-enable generator.
//   Every CTL field position depends on the divider field width DIV_W, so the
//   layout is expressed as functions of DIV_W rather than as fixed constants:
//     [DIV_W-1:0] DIV  divide ratio 2^DIV
//     [DIV_W]     SEL  tick source (0 = mclk, 1 = synchronised LFXT edge)
//     [DIV_W+1]   OFF  channel off (counter frozen, no pulses)
//   The CTL register occupies the low byte of its peripheral word only.
// -----------------------------------------------------------------------------
package omsp_clkgen_pkg;

  localparam int CTL_BYTE_W = 8;

  // Width of the per-channel divide counter: enough bits to cover the largest
  // ratio 2^(2^DIV_W - 1).
  function automatic int cnt_width(input int div_w);
    return (1 << div_w) - 1;
  endfunction

  function automatic int sel_pos(input int div_w);
    return div_w;
  endfunction

  function automatic int off_pos(input int div_w);
    return div_w + 1;
  endfunction

  function automatic int ctl_width(input int div_w);
    return div_w + 2;
  endfunction

  // Writable bits of CTL. SEL is only writable when the LFXT path exists, so
  // it reads back 0 in builds without the synchroniser.
  function automatic logic [CTL_BYTE_W-1:0] ctl_mask(input int div_w, input bit lfxt_en);
    logic [CTL_BYTE_W-1:0] m;
    m = CTL_BYTE_W'((1 << div_w) - 1);
    if (lfxt_en) m[sel_pos(div_w)] = 1'b1;
    m[off_pos(div_w)] = 1'b1;
    return m;
  endfunction

endpackage

// File: rtl/omsp_clkgen_ch.sv
// -----------------------------------------------------------------------------
// omsp_clkgen_ch
//   One clock-enable channel: its CTL register, the free-running divide
//   counter and the registered clk_en flop.
//
//   Ports
//     mclk       system clock
//     puc        synchronous active-high reset
//     ctl_wr     write strobe for this channel's CTL (already address-decoded)
//     ctl_wdata  write data (low CTL_W bits of the bus word)
//     lfxt_tick  single-cycle synchronised LFXT rising-edge tick
//     gate       hold-off: freezes the counter and blocks pulses
//     ctl        current CTL contents, for the read mux
//     clk_en     one-cycle enable pulse, one cycle after its qualifying tick
// -----------------------------------------------------------------------------
module omsp_clkgen_ch
  import omsp_clkgen_pkg::*;
#(
  parameter int DIV_W   = 3,
  parameter bit LFXT_EN = 1'b0
) (
  input  logic                      mclk,
  input  logic                      puc,
  input  logic                      ctl_wr,
  input  logic [ctl_width(DIV_W)-1:0] ctl_wdata,
  input  logic                      lfxt_tick,
  input  logic                      gate,
  output logic [ctl_width(DIV_W)-1:0] ctl,
  output logic                      clk_en
);

  localparam int CTL_W = ctl_width(DIV_W);
  localparam int CNT_W = cnt_width(DIV_W);
  localparam int SEL_P = sel_pos(DIV_W);
  localparam int OFF_P = off_pos(DIV_W);
  localparam logic [CTL_BYTE_W-1:0] CTL_MASK = ctl_mask(DIV_W, LFXT_EN);

  logic [CTL_W-1:0] ctl_q;
  logic [CNT_W-1:0] cnt_q;
  logic [DIV_W-1:0] div;
  logic             sel;
  logic             off;
  logic             tick_in;
  logic [CNT_W-1:0] div_mask;
  logic             phase_done;

  assign div = ctl_q[DIV_W-1:0];
  assign sel = ctl_q[SEL_P];
  assign off = ctl_q[OFF_P];

  assign tick_in = (sel ? lfxt_tick : 1'b1) & ~off & ~gate;

  // Low DIV bits of the counter all ones marks the last tick of a period.
  // With DIV = 0 the mask is empty, so every tick qualifies.
  assign div_mask   = (CNT_W'(1) << div) - CNT_W'(1);
  assign phase_done = (cnt_q & div_mask) == div_mask;

  // NOTE: state registers use non-blocking assignments so every flop samples
  // the pre-edge values; blocking here would make cnt_q/clk_en order-dependent.
  always_ff @(posedge mclk) begin
    if (puc) begin
      ctl_q  <= '0;
      cnt_q  <= '0;
      clk_en <= 1'b0;
    end else if (ctl_wr) begin
      // A write restarts the channel from phase zero and cancels any pulse
      // that would have been issued this cycle.
      ctl_q  <= ctl_wdata & CTL_MASK[CTL_W-1:0];
      cnt_q  <= '0;
      clk_en <= 1'b0;
    end else begin
      if (tick_in && (div != '0)) cnt_q <= cnt_q + CNT_W'(1);
      clk_en <= tick_in & phase_done;
    end
  end

  assign ctl = ctl_q;

endmodule

// File: rtl/omsp_clkgen_multi.sv
// -----------------------------------------------------------------------------
// omsp_clkgen_multi
//   Parametrised multi-channel clock-enable generator. NUM_CH independent
//   channels each emit single-cycle clk_en pulses at mclk / 2^DIV or at
//   (LFXT edge rate) / 2^DIV. Each channel has one CTL register at word
//   address BASE_ADDR + i on the peripheral bus (low byte only).
//
//   Build option: define OMSP_CLKGEN_LFXT_EN to include the LFXT synchroniser,
//   edge detector and the SEL bit. Without it lfxt_clk/oscoff are ignored,
//   SEL reads 0 and every channel counts mclk cycles.
//
//   Ports
//     mclk      system clock (only clock)
//     puc       synchronous active-high reset
//     per_addr  peripheral word address
//     per_din   peripheral write data
//     per_en    peripheral access enable
//     per_wen   byte write enables ([0] low, [1] high); 0 = read
//     per_dout  read data, 0 when no CTL register is addressed
//     lfxt_clk  asynchronous low-frequency oscillator
//     oscoff    suppresses all LFXT ticks while high
//     ch_gate   per-channel hold-off, high freezes the channel
//     clk_en    registered per-channel enable pulses
// -----------------------------------------------------------------------------
module omsp_clkgen_multi
  import omsp_clkgen_pkg::*;
#(
  parameter int         NUM_CH    = 3,
  parameter logic [7:0] BASE_ADDR = 8'h30,
  parameter int         DIV_W     = 3
) (
  input  logic              mclk,
  input  logic              puc,
  input  logic [7:0]        per_addr,
  input  logic [15:0]       per_din,
  input  logic              per_en,
  input  logic [1:0]        per_wen,
  output logic [15:0]       per_dout,
  input  logic              lfxt_clk,
  input  logic              oscoff,
  input  logic [NUM_CH-1:0] ch_gate,
  output logic [NUM_CH-1:0] clk_en
);

  localparam int CTL_W = ctl_width(DIV_W);

  logic lfxt_tick;

`ifdef OMSP_CLKGEN_LFXT_EN
  localparam bit LFXT_EN = 1'b1;

  // Two flops resolve metastability, the third holds the previous sample
  // for rising-edge detection.
  logic [2:0] lfxt_sync;

  always_ff @(posedge mclk) begin
    if (puc) lfxt_sync <= '0;
    else     lfxt_sync <= {lfxt_sync[1:0], lfxt_clk};
  end

  assign lfxt_tick = lfxt_sync[1] & ~lfxt_sync[2] & ~oscoff;
`else
  localparam bit LFXT_EN = 1'b0;

  logic unused_lfxt;
  assign unused_lfxt = lfxt_clk ^ oscoff;
  assign lfxt_tick   = 1'b0;
`endif

  // CTL lives in the low byte; the upper data bits are never stored.
  logic unused_din;
  assign unused_din = ^per_din[15:CTL_W];

  logic              wr_en;
  logic              rd_en;
  logic [NUM_CH-1:0] ch_hit;
  logic [CTL_W-1:0]  ctl_rd [NUM_CH];

  assign wr_en = per_en & per_wen[0];
  assign rd_en = per_en & (per_wen == 2'b00);

  for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
    assign ch_hit[i] = (per_addr == 8'(BASE_ADDR + i));

    omsp_clkgen_ch #(
      .DIV_W   (DIV_W),
      .LFXT_EN (LFXT_EN)
    ) u_ch (
      .mclk      (mclk),
      .puc       (puc),
      .ctl_wr    (wr_en & ch_hit[i]),
      .ctl_wdata (per_din[CTL_W-1:0]),
      .lfxt_tick (lfxt_tick),
      .gate      (ch_gate[i]),
      .ctl       (ctl_rd[i]),
      .clk_en    (clk_en[i])
    );
  end

  // NOTE: per_dout gets a default before the loop so every path assigns it;
  // otherwise an unaddressed read would hold its old value and infer a latch.
  always_comb begin
    per_dout = '0;
    for (int i = 0; i < NUM_CH; i++) begin
      if (rd_en && ch_hit[i]) per_dout = per_dout | 16'(ctl_rd[i]);
    end
  end

endmodule
